// File: rtl/serial_word_adder.sv
// Digit-serial adder/subtractor: LSD-first operands, one result digit per valid cycle.
// Define SERIAL_WORD_ADDER_OVERFLOW_EN to generate the signed-overflow flag; otherwise overflow is tied to 0.
module serial_word_adder #(
  parameter int DIGIT_W = 1,
  parameter int WORD_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               sub,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  output logic               out_valid,
  output logic [DIGIT_W-1:0] sum,
  output logic               out_last,
  output logic               carry_out,
  output logic               overflow
);

  localparam int NDIG = (DIGIT_W > 0) ? WORD_W / DIGIT_W : 1;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NDIG - 1);

  generate
    if (DIGIT_W <= 0 || WORD_W <= 0 || (WORD_W % DIGIT_W) != 0) begin : g_bad_params
      $error("serial_word_adder: WORD_W must be a positive multiple of DIGIT_W");
    end
  endgenerate

  logic [CW-1:0]    cnt;
  logic             carry;
  logic             mode;

  logic             first;
  logic             last;
  logic             mode_eff;
  logic             cin;
  logic [DIGIT_W-1:0] bp;
  logic [DIGIT_W:0] res;

  // The first digit of a word takes its mode and carry-in straight from sub,
  // so a word can start on the cycle right after the previous one ends.
  always_comb begin
    first    = (cnt == '0);
    last     = (cnt == LAST_CNT);
    mode_eff = first ? sub : mode;
    cin      = first ? sub : carry;
    bp       = mode_eff ? ~b : b;
    res      = {1'b0, a} + {1'b0, bp} + {{DIGIT_W{1'b0}}, cin};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      carry     <= 1'b0;
      mode      <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      out_last  <= 1'b0;
      carry_out <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        cnt       <= last ? '0 : cnt + CW'(1);
        carry     <= res[DIGIT_W];
        mode      <= mode_eff;
        sum       <= res[DIGIT_W-1:0];
        out_last  <= last;
        carry_out <= res[DIGIT_W];
      end
    end
  end

`ifdef SERIAL_WORD_ADDER_OVERFLOW_EN
  logic msb_cin;

  // Carry into the MSB recovered from the MSB's own sum bit.
  always_comb begin
    msb_cin = res[DIGIT_W-1] ^ a[DIGIT_W-1] ^ bp[DIGIT_W-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (in_valid) begin
      overflow <= last ? (msb_cin ^ res[DIGIT_W]) : 1'b0;
    end
  end
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_adder.sv
// Randomized/directed bench for serial_word_adder: a 1-bit x 16 instance and a 4-bit x 8 instance
// checked against whole-word arithmetic.
module tb_serial_word_adder;

  logic        clk = 1'b0;
  logic        rst;

  logic        in_valid, sub, a, b;
  logic        out_valid, sum, out_last, carry_out, overflow;

  logic        in_valid4, sub4;
  logic [3:0]  a4, b4, sum4;
  logic        out_valid4, out_last4, carry_out4, overflow4;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_word_adder #(.DIGIT_W(1), .WORD_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sub(sub), .a(a), .b(b),
    .out_valid(out_valid), .sum(sum), .out_last(out_last),
    .carry_out(carry_out), .overflow(overflow)
  );

  serial_word_adder #(.DIGIT_W(4), .WORD_W(8)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .sub(sub4), .a(a4), .b(b4),
    .out_valid(out_valid4), .sum(sum4), .out_last(out_last4),
    .carry_out(carry_out4), .overflow(overflow4)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Whole-word reference: result, carry and signed overflow of a +/- b.
  task automatic ref16(input logic [15:0] wa, input logic [15:0] wb, input logic ws,
                       output logic [16:0] r, output logic ov);
    logic [15:0] bp;
    bp = ws ? ~wb : wb;
    r  = {1'b0, wa} + {1'b0, bp} + 17'(ws);
`ifdef SERIAL_WORD_ADDER_OVERFLOW_EN
    ov = ws ? ($signed(wa) - $signed(wb) > 32767 || $signed(wa) - $signed(wb) < -32768)
            : ($signed(wa) + $signed(wb) > 32767 || $signed(wa) + $signed(wb) < -32768);
`else
    ov = 1'b0;
`endif
  endtask

  task automatic send_word(input logic [15:0] wa, input logic [15:0] wb, input logic ws,
                           input int gap_max, input bit toggle);
    logic [16:0] r;
    logic        ov;
    int          n;
    ref16(wa, wb, ws, r, ov);
    for (int i = 0; i < 16; i++) begin
      n = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      repeat (n) begin
        in_valid = 1'b0;
        a = 1'($urandom); b = 1'($urandom); sub = 1'($urandom);
        @(posedge clk); #1;
        chk("idle_out_valid", 16'(out_valid), 16'd0);
      end
      in_valid = 1'b1;
      a = wa[i];
      b = wb[i];
      sub = (i == 0 || !toggle) ? ws : 1'($urandom);
      @(posedge clk); #1;
      chk("out_valid", 16'(out_valid), 16'd1);
      chk("sum_digit", 16'(sum), 16'(r[i]));
      chk("out_last", 16'(out_last), 16'(i == 15));
      if (i == 15) begin
        chk("carry_out", 16'(carry_out), 16'(r[16]));
        chk("overflow", 16'(overflow), 16'(ov));
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_word4(input logic [7:0] wa, input logic [7:0] wb, input logic ws);
    logic [8:0] r;
    logic [7:0] bp;
    logic       ov;
    bp = ws ? ~wb : wb;
    r  = {1'b0, wa} + {1'b0, bp} + 9'(ws);
`ifdef SERIAL_WORD_ADDER_OVERFLOW_EN
    ov = ws ? ($signed(wa) - $signed(wb) > 127 || $signed(wa) - $signed(wb) < -128)
            : ($signed(wa) + $signed(wb) > 127 || $signed(wa) + $signed(wb) < -128);
`else
    ov = 1'b0;
`endif
    for (int i = 0; i < 2; i++) begin
      in_valid4 = 1'b1;
      a4 = wa[i*4 +: 4];
      b4 = wb[i*4 +: 4];
      sub4 = (i == 0) ? ws : ~ws;
      @(posedge clk); #1;
      chk("d4_out_valid", 16'(out_valid4), 16'd1);
      chk("d4_sum_digit", 16'(sum4), 16'(r[i*4 +: 4]));
      chk("d4_out_last", 16'(out_last4), 16'(i == 1));
      if (i == 1) begin
        chk("d4_carry_out", 16'(carry_out4), 16'(r[8]));
        chk("d4_overflow", 16'(overflow4), 16'(ov));
      end
    end
    in_valid4 = 1'b0;
    @(posedge clk); #1;
    chk("d4_idle_out_valid", 16'(out_valid4), 16'd0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; sub = 1'b0; a = 1'b0; b = 1'b0;
    in_valid4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_sum", 16'(sum), 16'd0);
    chk("rst_out_last", 16'(out_last), 16'd0);
    chk("rst_carry_out", 16'(carry_out), 16'd0);
    chk("rst_overflow", 16'(overflow), 16'd0);
    chk("rst_d4_out_valid", 16'(out_valid4), 16'd0);
    chk("rst_d4_sum", 16'(sum4), 16'd0);
    rst = 1'b0;

    // Directed add / subtract words, back to back
    send_word(16'h4DB4, 16'h1D62, 1'b0, 0, 1'b0);
    send_word(16'h4DB4, 16'h1D62, 1'b1, 0, 1'b0);
    send_word(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
    send_word(16'h8000, 16'h0001, 1'b1, 0, 1'b0);
    send_word(16'h0000, 16'h0001, 1'b1, 0, 1'b0);

    for (int k = 0; k < 6; k++)
      send_word(16'($urandom), 16'($urandom), 1'($urandom), 0, 1'b0);

    // Stalls between digits and sub toggling mid-word
    send_word(16'h4DB4, 16'h1D62, 1'b0, 3, 1'b1);
    send_word(16'h4DB4, 16'h1D62, 1'b1, 3, 1'b1);
    for (int k = 0; k < 4; k++)
      send_word(16'($urandom), 16'($urandom), 1'($urandom), 2, 1'b1);

    // Reset mid-word: three digits, then reset while in_valid is still high
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 1'b1; b = 1'b1; sub = 1'b1;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out_valid", 16'(out_valid), 16'd0);
    chk("midrst_sum", 16'(sum), 16'd0);
    chk("midrst_out_last", 16'(out_last), 16'd0);
    chk("midrst_carry_out", 16'(carry_out), 16'd0);
    rst = 1'b0;
    in_valid = 1'b0;
    send_word(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);

    // Wide-digit instance
    send_word4(8'h7F, 8'h01, 1'b0);
    send_word4(8'h80, 8'h01, 1'b1);
    send_word4(8'hFF, 8'hFF, 1'b0);
    for (int k = 0; k < 6; k++)
      send_word4(8'($urandom), 8'($urandom), 1'($urandom));

    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_word_adder.md
SERIAL_WORD_ADDER -- requirements
Module: serial_word_adder

Interface
REQ-001 Parameter DIGIT_W, default 1: bits consumed and produced per valid cycle.
REQ-002 Parameter WORD_W, default 16: operand word length in bits; SHALL be a positive multiple of DIGIT_W, with an elaboration-time error otherwise.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  a, b and sub are valid this cycle.
REQ-006 sub  input  1  0 = add (a+b), 1 = subtract (a-b); sampled on the first digit of each word only.
REQ-007 a  input  DIGIT_W  operand A digit, least-significant digit first.
REQ-008 b  input  DIGIT_W  operand B digit, least-significant digit first.
REQ-009 out_valid  output  1  sum digit valid.
REQ-010 sum  output  DIGIT_W  result digit.
REQ-011 out_last  output  1  the current sum digit is the word's most-significant digit.
REQ-012 carry_out  output  1  final carry of the word; valid only when out_valid and out_last are both 1.
REQ-013 overflow  output  1  signed two's-complement overflow of the word; valid only when out_valid and out_last are both 1.

Function
REQ-014 NDIG = WORD_W/DIGIT_W; the digit counter has width max(1, $clog2(NDIG)).
REQ-015 The digit counter SHALL advance only on cycles with in_valid=1, and SHALL wrap from NDIG-1 to 0.
REQ-016 When in_valid=0, all internal state (counter, carry, latched mode) SHALL hold; stalls of any length between digits are legal.
REQ-017 On the first digit (counter=0), the latched mode SHALL be loaded from sub, and the carry-in SHALL be sub.
REQ-018 On every later digit, the carry-in SHALL be the registered carry and sub SHALL be ignored.
REQ-019 Per digit: operand B' = latched mode ? ~b : b.
REQ-020 Per digit: {c, s} = a + B' + carry-in, computed DIGIT_W+1 bits wide; c is written to the carry register.
REQ-021 All outputs SHALL be registered with latency exactly one cycle: the digit accepted at edge k appears on sum at edge k+1.
REQ-022 out_valid SHALL equal in_valid delayed by one cycle, and the other outputs SHALL update only when in_valid=1.
REQ-023 out_last SHALL be 1 exactly for the digit accepted at counter=NDIG-1.
REQ-024 On the last digit, carry_out SHALL be c; in subtract mode, carry_out=1 means no borrow.
REQ-025 After the last digit, the carry register is don't-care, because the next word's first digit reloads the carry-in.
REQ-026 A sub change during a word SHALL have no effect until the next word.
REQ-027 With NDIG=1, every valid digit is both first and last: carry-in=sub and out_last=1.

Reset
REQ-028 While rst=1 at a clock edge, the module SHALL clear: out_valid=0, sum=0, out_last=0, carry_out=0, overflow=0, counter=0, carry=0, latched mode=0.
REQ-029 Reset has priority over in_valid; a reset mid-word SHALL abandon the partial word, and the next valid digit SHALL be treated as a first digit.

Configuration
REQ-030 Macro SERIAL_WORD_ADDER_OVERFLOW_EN, when defined: on the last digit, overflow SHALL be the carry into the MSB XOR the carry out of the MSB, registered alongside sum.
REQ-031 When SERIAL_WORD_ADDER_OVERFLOW_EN is not defined, the overflow port SHALL still exist and SHALL be constant 0; no overflow logic is synthesised.

Verification
REQ-032 Add (DIGIT_W=1, WORD_W=16): a=0x4DB4, b=0x1D62, sub=0, 16 back-to-back digits -> sum digits form 0x6B16; out_last on the 16th output; carry_out=0; overflow=0.
REQ-033 Subtract (DIGIT_W=1, WORD_W=16): a=0x4DB4, b=0x1D62, sub=1 -> 0x3052; carry_out=1; overflow=0.
REQ-034 Overflow (DIGIT_W=4, WORD_W=8, macro defined): a=0x7F, b=0x01, sub=0 -> digits 0x0 then 0x8; carry_out=0; overflow=1. The same case without the macro -> overflow=0.
REQ-035 Stalls: run the REQ-032 stimulus with random in_valid gaps and toggle sub mid-word -> identical result; out_valid pulses only one cycle after each accepted digit.
REQ-036 Reset mid-word: assert rst after 3 digits, then feed a=0xFFFF, b=0x0001, sub=0 -> sum=0x0000, carry_out=1, overflow=0, out_last on the 16th post-reset digit.
